// File: rtl/sq_wave_monitor.sv
// sq_wave_monitor: measures period/high time of async sig_in in clk cycles; windows in (period/high min/max), meas_valid/period_cycles/high_cycles/in_spec/stuck_hi/stuck_lo out
module sq_wave_monitor #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] period_min,
  input  logic [CNT_W-1:0] period_max,
  input  logic [CNT_W-1:0] high_min,
  input  logic [CNT_W-1:0] high_max,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic             in_spec,
  output logic             stuck_hi,
  output logic             stuck_lo
);
  typedef enum logic [2:0] {IDLE, HIGH, LOW, WAIT_RISE, STUCK} state_t;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);
  state_t state_q, state_d;
  logic s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
  logic [1:0] warm_q, warm_d;
  logic [CNT_W-1:0] lvl_cnt_q, lvl_cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d, sum;
  logic meas_valid_q, meas_valid_d, in_spec_q, in_spec_d;
  logic stuck_hi_q, stuck_hi_d, stuck_lo_q, stuck_lo_d;
  logic rise, fall, edg, timeout;
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;
    edg = rise | fall;
    warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    lvl_cnt_d = edg ? CNT_W'(1) : (lvl_cnt_q == TMO ? TMO : lvl_cnt_q + 1'b1);
    timeout = !edg && lvl_cnt_d == TMO && state_q != STUCK;
    sum = hcnt_q + lvl_cnt_q;
    state_d = state_q;
    hcnt_d = hcnt_q;
    meas_valid_d = 1'b0;
    period_d = period_q;
    high_d = high_q;
    in_spec_d = in_spec_q;
    stuck_hi_d = stuck_hi_q & state_q == STUCK & !edg;
    stuck_lo_d = stuck_lo_q & state_q == STUCK & !edg;
    if (timeout) begin
      state_d = STUCK;
      stuck_hi_d = s2_q;
      stuck_lo_d = ~s2_q;
    end else begin
      case (state_q)
        // until the synchronizer refills after reset, s2 vs s3 compares against reset zeros
        IDLE: state_d = warm_q != 2'd3 ? IDLE : rise ? HIGH : fall ? WAIT_RISE : IDLE;
        HIGH: if (fall) begin
          state_d = LOW;
          hcnt_d = lvl_cnt_q;
        end
        LOW: if (rise) begin
          state_d = HIGH;
          meas_valid_d = 1'b1;
          high_d = hcnt_q;
          period_d = sum;
          in_spec_d = period_min <= sum && sum <= period_max && high_min <= hcnt_q && hcnt_q <= high_max;
        end
        WAIT_RISE: state_d = rise ? HIGH : WAIT_RISE;
        STUCK: state_d = rise ? HIGH : fall ? WAIT_RISE : STUCK;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      warm_q <= '0;
      lvl_cnt_q <= '0;
      hcnt_q <= '0;
      meas_valid_q <= 1'b0;
      period_q <= '0;
      high_q <= '0;
      in_spec_q <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      warm_q <= warm_d;
      lvl_cnt_q <= lvl_cnt_d;
      hcnt_q <= hcnt_d;
      meas_valid_q <= meas_valid_d;
      period_q <= period_d;
      high_q <= high_d;
      in_spec_q <= in_spec_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end
  assign meas_valid = meas_valid_q;
  assign period_cycles = period_q;
  assign high_cycles = high_q;
  assign in_spec = in_spec_q;
  assign stuck_hi = stuck_hi_q;
  assign stuck_lo = stuck_lo_q;
endmodule

// File: tb/tb_sq_wave_monitor.sv
// tb_sq_wave_monitor: directed checks of sq_wave_monitor with TIMEOUT_CYC=100
module tb_sq_wave_monitor;
  logic clk = 1'b0, rst = 1'b1, sig_in = 1'b0;
  logic [15:0] period_min = 16'd38, period_max = 16'd42, high_min = 16'd14, high_max = 16'd18;
  logic meas_valid, in_spec, stuck_hi, stuck_lo;
  logic [15:0] period_cycles, high_cycles;
  int checks = 0, errors = 0;
  int mv_n = 0, st_n = 0, both_n = 0, mv0, s0;
  sq_wave_monitor #(.CNT_W(16), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .period_min(period_min), .period_max(period_max),
    .high_min(high_min), .high_max(high_max),
    .meas_valid(meas_valid), .period_cycles(period_cycles), .high_cycles(high_cycles),
    .in_spec(in_spec), .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (meas_valid) mv_n++;
    if (stuck_hi | stuck_lo) st_n++;
    if (stuck_hi & stuck_lo) both_n++;
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input int n);
    sig_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic meas(input string tag, input int p, input int h, input int s);
    chk({tag, "_period"}, int'(period_cycles), p);
    chk({tag, "_high"}, int'(high_cycles), h);
    chk({tag, "_in_spec"}, int'(in_spec), s);
  endtask
  initial begin
    drive(0, 3);
    chk("rst_valid", int'(meas_valid), 0);
    meas("rst", 0, 0, 0);
    chk("rst_stuck", int'({stuck_hi, stuck_lo}), 0);
    rst = 1'b0;
    drive(0, 10);
    mv0 = mv_n;
    for (int i = 0; i < 3; i++) begin
      drive(1, 16);
      drive(0, 24);
    end
    drive(1, 24);
    chk("setup_count", mv_n - mv0, 3);
    meas("setup", 40, 16, 1);
    drive(0, 16);
    drive(1, 4);
    chk("duty_count", mv_n - mv0, 4);
    meas("duty", 40, 24, 0);
    drive(1, 10);
    drive(0, 28);
    drive(1, 4);
    meas("edge42", 42, 14, 1);
    drive(1, 14);
    drive(0, 25);
    drive(1, 4);
    meas("edge43", 43, 18, 0);
    drive(1, 14);
    drive(0, 10);
    period_max = 16'd0;
    drive(0, 10);
    period_max = 16'd42;
    drive(1, 4);
    meas("win_sample", 38, 18, 1);
    drive(1, 12);
    drive(0, 24);
    high_min = 16'd18;
    high_max = 16'd14;
    drive(1, 4);
    meas("inverted", 40, 16, 0);
    high_min = 16'd14;
    high_max = 16'd18;
    s0 = st_n;
    drive(1, 95);
    drive(0, 20);
    chk("no_stuck_99", st_n - s0, 0);
    drive(1, 4);
    meas("long_high", 119, 99, 0);
    s0 = st_n;
    mv0 = mv_n;
    drive(1, 96);
    drive(0, 20);
    chk("stuck_hi_100", st_n - s0, 1);
    chk("stuck_hi_clr", int'(stuck_hi), 0);
    drive(1, 16);
    drive(0, 24);
    chk("no_meas_stuck", mv_n - mv0, 0);
    drive(1, 4);
    chk("post_stuck_count", mv_n - mv0, 1);
    meas("post_stuck", 40, 16, 1);
    drive(1, 12);
    mv0 = mv_n;
    drive(0, 110);
    chk("stuck_lo_set", int'(stuck_lo), 1);
    chk("stuck_lo_hi", int'(stuck_hi), 0);
    drive(1, 5);
    chk("stuck_lo_clr", int'(stuck_lo), 0);
    drive(1, 11);
    drive(0, 24);
    chk("no_meas_stuck_lo", mv_n - mv0, 0);
    drive(1, 4);
    chk("post_stuck_lo_count", mv_n - mv0, 1);
    drive(1, 5);
    rst = 1'b1;
    drive(1, 1);
    chk("midrst_valid", int'(meas_valid), 0);
    meas("midrst", 0, 0, 0);
    chk("midrst_stuck", int'({stuck_hi, stuck_lo}), 0);
    drive(1, 2);
    rst = 1'b0;
    mv0 = mv_n;
    drive(1, 10);
    drive(0, 20);
    drive(1, 16);
    chk("rst_no_early", mv_n - mv0, 0);
    drive(0, 24);
    drive(1, 4);
    chk("rst_first_count", mv_n - mv0, 1);
    meas("rst_first", 40, 16, 1);
    drive(1, 16);
    drive(0, 20);
    sig_in = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat_e%0d", e), int'(meas_valid), e == 3 ? 1 : 0);
    end
    meas("lat", 40, 20, 0);
    chk("never_both", both_n, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
